gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
- Parametrised GCD engine with valid/ready handshakes on input and output.
- Two run-time algorithms, selected per operation:
  - subtract-and-swap Euclid;
  - binary Stein (shift/subtract).
- Reports the iteration count and flags the both-operands-zero case.
- Sits between an operand source and a result consumer. It is the next-generation arithmetic core for the VLSI experiment datapaths.

Parameters:
- WIDTH, 16, operand and result width in bits (legal 4..32).
- CYC_W, 16, width of the iteration counter (saturating).
- KW, 5, width of the Stein common-power-of-two counter; must satisfy 2^KW > WIDTH.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a_in/b_in/mode valid.
- in_ready  output  1  engine can accept operands.
- a_in  input  WIDTH  operand A (unsigned).
- b_in  input  WIDTH  operand B (unsigned).
- mode  input  1  0 = Euclid subtract/swap, 1 = binary Stein.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- g_out  output  WIDTH  GCD result; 0 when out_valid=0.
- cycles_out  output  CYC_W  BUSY cycles used by this operation; 0 when out_valid=0.
- zero_err  output  1  both operands were 0; 0 when out_valid=0.

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk.
  - On reset: state=IDLE; A, B, k, cnt, result, zero_err registers all cleared.
  - Outputs after reset: in_ready=1, out_valid=0, g_out=0, cycles_out=0, zero_err=0.
  - Reset mid-operation discards the operation; no result is produced.
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch A=a_in, B=b_in, mode_r=mode, k=0, cnt=0, zero_err_r=(a_in==0 && b_in==0); go to BUSY.
- BUSY:
  - in_ready=0; inputs ignored.
  - Every edge increments cnt, saturating at 2^CYC_W-1, then applies exactly one step of mode_r.
- Euclid step (mode_r=0), priority order:
  - B==0: result=A, go DONE.
  - else A<B: swap (A=B, B=A).
  - else A=A-B.
- Stein step (mode_r=1), priority order:
  - A==0: result=B<<k, go DONE.
  - else B==0: result=A<<k, go DONE.
  - else both even: A>>=1, B>>=1, k++.
  - else A even: A>>=1.
  - else B even: B>>=1.
  - else A>=B: A=(A-B)>>1.
  - else B=(B-A)>>1.
  - The shift by k is combinational into the result register at the terminating edge. Width is WIDTH; no overflow is possible.
- DONE:
  - out_valid=1; g_out=result, cycles_out=cnt, zero_err=zero_err_r, all held stable until accepted.
  - Edge with out_ready=1: go IDLE; outputs return to 0 on the next cycle.
  - in_ready=0 throughout DONE, so a new input is accepted at the earliest on the cycle after the result handshake.
- Latency: operation accepted at edge t0; result visible after edge t0+cnt. The terminating BUSY edge is counted.
- Boundaries:
  - Both operands 0: result 0, zero_err=1, cycles=1 in either mode.
  - One operand 0: result = the other operand.
  - a==b: valid in both modes.
  - out_ready held high before DONE: ignored until out_valid=1.
  - in_valid held high during BUSY/DONE: ignored (no queueing).
  - Counter saturates without wrap, e.g. Euclid (2^WIDTH-1, 1) with small CYC_W.
  - No combinational path from in_valid to in_ready or from out_ready to out_valid.

Test Plan:
- WIDTH=8, mode=0, a=12, b=8, out_ready=1 -> g_out=4, cycles_out=6, zero_err=0, out_valid high for 1 cycle; in_ready back to 1 one cycle later.
- WIDTH=8, mode=1, a=12, b=8 -> g_out=4, cycles_out=6. Also a=48, b=18 mode=1 -> g_out=6.
- mode 0 and mode 1, a=0, b=0 -> g_out=0, zero_err=1, cycles_out=1. Also a=0, b=35 -> g_out=35, zero_err=0.
- Backpressure: a=255, b=85 mode=0, out_ready=0 for 10 cycles after out_valid -> g_out=85 and cycles_out constant, in_ready=0; operands driven with in_valid=1 during that time are not accepted.
- Saturation: CYC_W=4, mode=0, a=255, b=1 -> g_out=1, cycles_out=15; the same operands with mode=1 -> g_out=1, cycles_out<15.
- Reset asserted asynchronously on BUSY cycle 3 of a=200, b=75 -> out_valid stays 0, in_ready=1 right after release; next op a=200, b=75 mode=0 -> g_out=25.

Source files
------------

// File: rtl/gcd_engine.sv
// GCD engine with valid/ready handshakes. Each operation picks either
// subtract-and-swap Euclid or binary Stein, and reports the BUSY cycle count.
module gcd_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CYC_W = 16,
  parameter int unsigned KW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g_out,
  output logic [CYC_W-1:0] cycles_out,
  output logic             zero_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             zerr_q, zerr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CYC_W-1:0] cyc_out_q, cyc_out_d;
  logic             zerr_out_q, zerr_out_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CYC_W-1:0] cnt_inc_c;
  logic             fin_c;

  // Saturating iteration counter: sticks at all-ones instead of wrapping.
  assign cnt_inc_c = (cnt_q == {CYC_W{1'b1}}) ? cnt_q : cnt_q + CYC_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      zerr_q      <= 1'b0;
      result_q    <= '0;
      cyc_out_q   <= '0;
      zerr_out_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      zerr_q      <= zerr_d;
      result_q    <= result_d;
      cyc_out_q   <= cyc_out_d;
      zerr_out_q  <= zerr_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    zerr_d      = zerr_q;
    result_d    = result_q;
    cyc_out_d   = cyc_out_q;
    zerr_out_d  = zerr_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    fin_c       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = a_in;
          b_d        = b_in;
          mode_d     = mode;
          k_d        = '0;
          cnt_d      = '0;
          zerr_d     = (a_in == '0) && (b_in == '0);
          in_ready_d = 1'b0;
          state_d    = S_BUSY;
        end
      end

      S_BUSY: begin
        cnt_d = cnt_inc_c;
        if (!mode_q) begin
          if (b_q == '0) begin
            result_d = a_q;
            fin_c    = 1'b1;
          end else if (a_q < b_q) begin
            a_d = b_q;
            b_d = a_q;
          end else begin
            a_d = a_q - b_q;
          end
        end else begin
          // Stein: restore the common power of two on the terminating step.
          if (a_q == '0) begin
            result_d = b_q << k_q;
            fin_c    = 1'b1;
          end else if (b_q == '0) begin
            result_d = a_q << k_q;
            fin_c    = 1'b1;
          end else if (!a_q[0] && !b_q[0]) begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            k_d = k_q + KW'(1);
          end else if (!a_q[0]) begin
            a_d = a_q >> 1;
          end else if (!b_q[0]) begin
            b_d = b_q >> 1;
          end else if (a_q >= b_q) begin
            a_d = (a_q - b_q) >> 1;
          end else begin
            b_d = (b_q - a_q) >> 1;
          end
        end
        if (fin_c) begin
          cyc_out_d   = cnt_inc_c;
          zerr_out_d  = zerr_q;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          result_d    = '0;
          cyc_out_d   = '0;
          zerr_out_d  = 1'b0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        result_d    = '0;
        cyc_out_d   = '0;
        zerr_out_d  = 1'b0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign g_out      = result_q;
  assign cycles_out = cyc_out_q;
  assign zero_err   = zerr_out_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine (WIDTH=8, CYC_W=4): directed operations plus a
// cycle-level reference model compared against the outputs on every falling edge.
module tb_gcd_engine;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CYC_W = 4;
  localparam int unsigned KW    = 4;
  localparam int          CYC_MAX = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] g_out;
  logic [CYC_W-1:0] cycles_out;
  logic             zero_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  gcd_engine #(.WIDTH(WIDTH), .CYC_W(CYC_W), .KW(KW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .g_out      (g_out),
    .cycles_out (cycles_out),
    .zero_err   (zero_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Mathematical GCD, independent of either hardware algorithm.
  function automatic int gcd_ref(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Number of BUSY cycles the Euclid rules take, terminating step included.
  function automatic int euclid_steps(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    for (int n = 1; n < 100000; n++) begin
      if (y == 0) return n;
      if (x < y) begin t = x; x = y; y = t; end
      else x = x - y;
    end
    return -1;
  endfunction

  function automatic int stein_steps(input int a, input int b);
    int x = a;
    int y = b;
    for (int n = 1; n < 100000; n++) begin
      if (x == 0 || y == 0) return n;
      if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
      else if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x >= y) x = (x - y) / 2;
      else y = (y - x) / 2;
    end
    return -1;
  endfunction

  // Reference model state: 0 idle, 1 busy, 2 done.
  int m_st   = 0;
  int m_left = 0;
  int m_g    = 0;
  int m_cyc  = 0;
  int m_z    = 0;

  always @(negedge clk) begin
    if (reset) begin
      m_st = 0;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_g_out", int'(g_out), 0);
      chk("rst_cycles_out", int'(cycles_out), 0);
      chk("rst_zero_err", int'(zero_err), 0);
    end else begin
      chk("mdl_in_ready", int'(in_ready), (m_st == 0) ? 1 : 0);
      chk("mdl_out_valid", int'(out_valid), (m_st == 2) ? 1 : 0);
      chk("mdl_g_out", int'(g_out), (m_st == 2) ? m_g : 0);
      chk("mdl_cycles_out", int'(cycles_out), (m_st == 2) ? m_cyc : 0);
      chk("mdl_zero_err", int'(zero_err), (m_st == 2) ? m_z : 0);
      case (m_st)
        0: if (in_valid) begin
          m_g    = gcd_ref(int'(a_in), int'(b_in));
          m_left = mode ? stein_steps(int'(a_in), int'(b_in))
                        : euclid_steps(int'(a_in), int'(b_in));
          m_cyc  = (m_left > CYC_MAX) ? CYC_MAX : m_left;
          m_z    = (a_in == 0 && b_in == 0) ? 1 : 0;
          m_st   = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_st = 2;
        end
        default: if (out_ready) m_st = 0;
      endcase
    end
  end

  // Submit one operation, wait for its result, check it against literals.
  task automatic run_op(input int a, input int b, input bit md, input bit ordy_early,
                        input int hold, input int eg, input int ec, input int ez);
    bit got;
    @(posedge clk); #1;
    a_in      = WIDTH'(a);
    b_in      = WIDTH'(b);
    mode      = md;
    in_valid  = 1'b1;
    out_ready = ordy_early;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    if (!got) chk("result_timeout", 0, 1);
    chk("op_g_out", int'(g_out), eg);
    chk("op_cycles_out", int'(cycles_out), ec);
    chk("op_zero_err", int'(zero_err), ez);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        in_valid = 1'b1;
        a_in     = WIDTH'(9);
        b_in     = WIDTH'(6);
      end
      @(negedge clk);
      chk("hold_g_out", int'(g_out), eg);
      chk("hold_cycles_out", int'(cycles_out), ec);
      chk("hold_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    mode      = 1'b0;
    out_ready = 1'b0;

    // Hand-computed values pinning the reference model.
    chk("pin_gcd_48_18", gcd_ref(48, 18), 6);
    chk("pin_eu_12_8", euclid_steps(12, 8), 6);
    chk("pin_st_12_8", stein_steps(12, 8), 6);
    chk("pin_eu_255_1", euclid_steps(255, 1), 257);
    chk("pin_st_255_1", stein_steps(255, 1), 9);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_op(12, 8, 1'b0, 1'b1, 0, 4, 6, 0);
    run_op(12, 8, 1'b1, 1'b1, 0, 4, 6, 0);
    run_op(48, 18, 1'b1, 1'b0, 0, 6, 7, 0);
    run_op(0, 0, 1'b0, 1'b0, 0, 0, 1, 1);
    run_op(0, 0, 1'b1, 1'b1, 0, 0, 1, 1);
    run_op(0, 35, 1'b0, 1'b0, 0, 35, 2, 0);
    run_op(0, 35, 1'b1, 1'b0, 0, 35, 1, 0);
    run_op(35, 0, 1'b1, 1'b1, 0, 35, 1, 0);
    run_op(7, 7, 1'b0, 1'b1, 0, 7, 3, 0);
    run_op(7, 7, 1'b1, 1'b1, 0, 7, 2, 0);
    run_op(255, 85, 1'b0, 1'b0, 10, 85, 5, 0);
    run_op(255, 1, 1'b0, 1'b1, 0, 1, 15, 0);
    run_op(255, 1, 1'b1, 1'b1, 0, 1, 9, 0);

    // Asynchronous reset in the middle of an operation discards it.
    @(posedge clk); #1;
    a_in     = WIDTH'(200);
    b_in     = WIDTH'(75);
    mode     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_out_valid", int'(out_valid), 0);
    run_op(200, 75, 1'b0, 1'b1, 0, 25, 9, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
